// File: rtl/servant_wb_loader_if.sv
// Byte-stream and Wishbone signals between servant_wb_loader and its neighbours.
// master: the loader; slave: the byte source plus the servant_ram Wishbone port.
interface servant_wb_loader_if #(
  parameter int unsigned aw = 7
) ();
  logic [7:0]    i_byte;
  logic          i_byte_valid;
  logic          o_byte_ready;
  logic [aw-3:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_cyc;
  logic [31:0]   i_wb_rdt;
  logic          i_wb_ack;

  modport master (
    input  i_byte, i_byte_valid, i_wb_rdt, i_wb_ack,
    output o_byte_ready, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );

  modport slave (
    output i_byte, i_byte_valid, i_wb_rdt, i_wb_ack,
    input  o_byte_ready, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );
endinterface

// File: rtl/servant_wb_loader.sv
// Packs a little-endian byte stream into words, writes them to servant_ram, then releases the CPU.
// Define LOADER_READBACK_EN to read back each word after writing it and flag mismatches on o_err.
module servant_wb_loader #(
  parameter int unsigned depth      = 128,
  parameter int unsigned aw         = $clog2(depth),
  parameter int unsigned LOAD_BYTES = depth
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst,
  servant_wb_loader_if.master wb,
  output logic                o_cpu_rst,
  output logic                o_done,
  output logic                o_err
);

  localparam int unsigned WAW        = aw - 2;
  localparam int unsigned LOAD_WORDS = LOAD_BYTES / 4;
  localparam logic [WAW-1:0] LAST_ADR = WAW'(LOAD_WORDS - 1);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    WRITE   = 3'd1,
    RD_GAP  = 3'd2,
    VERIFY  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [23:0]    shift_q, shift_d;
  logic [WAW-1:0] adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic           we_q, we_d;
  logic           cyc_q, cyc_d;
  logic           ready_q, ready_d;
  logic           cpu_rst_q, cpu_rst_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           take_c;
  logic           ack_c;
  logic           advance_c;

  assign take_c = ready_q & wb.i_byte_valid;
  // An ack only counts while a cycle is actually open.
  assign ack_c  = wb.i_wb_ack & cyc_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    ready_d    = ready_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    advance_c  = 1'b0;

    case (state_q)
      COLLECT: begin
        ready_d = 1'b1;
        if (take_c) begin
          shift_d    = {wb.i_byte, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            dat_d   = {wb.i_byte, shift_q};
            ready_d = 1'b0;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (ack_c) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
`ifdef LOADER_READBACK_EN
          state_d = RD_GAP;
`else
          advance_c = 1'b1;
`endif
        end
      end
`ifdef LOADER_READBACK_EN
      // One idle cycle so the slave's ack toggle restarts before the read.
      RD_GAP: begin
        cyc_d   = 1'b1;
        state_d = VERIFY;
      end
      VERIFY: begin
        if (ack_c) begin
          cyc_d = 1'b0;
          if (wb.i_wb_rdt != dat_q) begin
            err_d = 1'b1;
          end
          advance_c = 1'b1;
        end
      end
`endif
      DONE: begin
        ready_d = 1'b0;
        cyc_d   = 1'b0;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    // Last word keeps its address so the pointer never wraps past the image.
    if (advance_c) begin
      if (adr_q == LAST_ADR) begin
        state_d   = DONE;
        done_d    = 1'b1;
        cpu_rst_d = 1'b0;
        ready_d   = 1'b0;
      end else begin
        adr_d   = adr_q + WAW'(1);
        state_d = COLLECT;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q    <= COLLECT;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      adr_q      <= '0;
      dat_q      <= 32'd0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      ready_q    <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      ready_q    <= ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wb.o_byte_ready = ready_q;
  assign wb.o_wb_adr     = adr_q;
  assign wb.o_wb_dat     = dat_q;
  assign wb.o_wb_sel     = 4'hF;
  assign wb.o_wb_we      = we_q;
  assign wb.o_wb_cyc     = cyc_q;
  assign o_cpu_rst       = cpu_rst_q;
  assign o_done          = done_q;

`ifdef LOADER_READBACK_EN
  assign o_err = err_q;
`else
  logic unused_rdt;
  logic unused_err;
  assign unused_rdt = ^wb.i_wb_rdt;
  assign unused_err = err_q;
  assign o_err      = 1'b0;
`endif

endmodule
